// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller.
// Holds the FSM state encoding, the op/func field values the decoder
// recognises, the ALU operation codes, the PC source selects and the
// per-instruction class record passed from the decoder to the FSM.
// No ports; imported by the interface, the decoder and the top.
package multicycle_ctrl_pkg;

  localparam logic [4:0] RA_REG = 5'd31;
  localparam int         AW     = 4;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [AW-1:0] ALUC_ADD = 4'b0000;
  localparam logic [AW-1:0] ALUC_SUB = 4'b0100;
  localparam logic [AW-1:0] ALUC_AND = 4'b0001;
  localparam logic [AW-1:0] ALUC_OR  = 4'b0101;
  localparam logic [AW-1:0] ALUC_XOR = 4'b0010;
  localparam logic [AW-1:0] ALUC_LUI = 4'b0110;
  localparam logic [AW-1:0] ALUC_SLL = 4'b0011;
  localparam logic [AW-1:0] ALUC_SRL = 4'b0111;
  localparam logic [AW-1:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // Instruction class plus the ALU-side controls, which depend only on
  // the instruction and not on the FSM state.
  typedef struct packed {
    logic          isRtype;
    logic          isIalu;
    logic          isLw;
    logic          isSw;
    logic          isBeq;
    logic          isBne;
    logic          isJ;
    logic          isJal;
    logic          isJr;
    logic          isIllegal;
    logic          aluimm;
    logic          sext;
    logic          shift;
    logic [AW-1:0] aluc;
  } insn_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the datapath.
// Instruction fields and memory handshakes flow datapath -> controller;
// the write enables, mux selects, ALU controls and debug state flow
// controller -> datapath.
//   master : controller side (drives the control outputs)
//   slave  : datapath side (drives op/func/rsrtequ/ready inputs)
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [5:0]    op;
  logic [5:0]    func;
  logic          rsrtequ;
  logic          imem_rdy;
  logic          dmem_rdy;

  logic          wpc;
  logic          wir;
  logic [1:0]    pcsrc;
  logic          aluimm;
  logic          sext;
  logic          shift;
  logic [AW-1:0] aluc;
  logic          regrt;
  logic          jal;
  logic          m2reg;
  logic          wreg;
  logic          wmem;
  logic          illegal;
  logic [2:0]    state;

  modport master (
    input  op, func, rsrtequ, imem_rdy, dmem_rdy,
    output wpc, wir, pcsrc, aluimm, sext, shift, aluc,
           regrt, jal, m2reg, wreg, wmem, illegal, state
  );

  modport slave (
    output op, func, rsrtequ, imem_rdy, dmem_rdy,
    input  wpc, wir, pcsrc, aluimm, sext, shift, aluc,
           regrt, jal, m2reg, wreg, wmem, illegal, state
  );

endinterface

// File: rtl/multicycle_ctrl_insn_decode.sv
// Combinational instruction decoder for the multicycle controller.
// Turns the IR op/func fields into a class record (which instruction
// family this is, or illegal) together with the ALU controls.
//   i_op   : IR[31:26]
//   i_func : IR[5:0]
//   o_cls  : class flags plus aluimm/sext/shift/aluc
module multicycle_ctrl_insn_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_func,
  output insn_class_t o_cls
);

  // Everything starts cleared with an add opcode, so each case arm only
  // has to raise the flags that belong to its instruction. Anything not
  // matched ends up flagged illegal with no class bit set, which keeps
  // the FSM from ever producing a write for it.
  always_comb begin
    o_cls      = '0;
    o_cls.aluc = ALUC_ADD;
    case (i_op)
      OP_RTYPE: begin
        o_cls.isRtype = 1'b1;
        case (i_func)
          FN_ADD: o_cls.aluc = ALUC_ADD;
          FN_SUB: o_cls.aluc = ALUC_SUB;
          FN_AND: o_cls.aluc = ALUC_AND;
          FN_OR:  o_cls.aluc = ALUC_OR;
          FN_XOR: o_cls.aluc = ALUC_XOR;
          FN_SLL: begin o_cls.aluc = ALUC_SLL; o_cls.shift = 1'b1; end
          FN_SRL: begin o_cls.aluc = ALUC_SRL; o_cls.shift = 1'b1; end
          FN_SRA: begin o_cls.aluc = ALUC_SRA; o_cls.shift = 1'b1; end
          FN_JR:  begin o_cls.isRtype = 1'b0; o_cls.isJr = 1'b1; end
          default: begin o_cls.isRtype = 1'b0; o_cls.isIllegal = 1'b1; end
        endcase
      end
      OP_ADDI: begin
        o_cls.isIalu = 1'b1; o_cls.aluimm = 1'b1; o_cls.sext = 1'b1;
        o_cls.aluc = ALUC_ADD;
      end
      OP_ANDI: begin o_cls.isIalu = 1'b1; o_cls.aluimm = 1'b1; o_cls.aluc = ALUC_AND; end
      OP_ORI:  begin o_cls.isIalu = 1'b1; o_cls.aluimm = 1'b1; o_cls.aluc = ALUC_OR;  end
      OP_XORI: begin o_cls.isIalu = 1'b1; o_cls.aluimm = 1'b1; o_cls.aluc = ALUC_XOR; end
      OP_LUI:  begin o_cls.isIalu = 1'b1; o_cls.aluimm = 1'b1; o_cls.aluc = ALUC_LUI; end
      OP_LW: begin
        o_cls.isLw = 1'b1; o_cls.aluimm = 1'b1; o_cls.sext = 1'b1;
        o_cls.aluc = ALUC_ADD;
      end
      OP_SW: begin
        o_cls.isSw = 1'b1; o_cls.aluimm = 1'b1; o_cls.sext = 1'b1;
        o_cls.aluc = ALUC_ADD;
      end
      OP_BEQ:  begin o_cls.isBeq = 1'b1; o_cls.sext = 1'b1; o_cls.aluc = ALUC_SUB; end
      OP_BNE:  begin o_cls.isBne = 1'b1; o_cls.sext = 1'b1; o_cls.aluc = ALUC_SUB; end
      OP_J:    o_cls.isJ = 1'b1;
      OP_JAL:  o_cls.isJal = 1'b1;
      default: o_cls.isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the MIPS-subset CPU. Steps each
// instruction through IF/ID/EX/MEM/WB, waiting in IF for the
// instruction memory and in MEM for the data memory.
//   clk  : rising-edge clock
//   clrn : synchronous active-low reset
//   bus  : control interface (master side), see multicycle_ctrl_if
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  multicycle_ctrl_if.master  bus
);

  state_t        r_state;
  state_t        w_next;
  insn_class_t   w_cls;

  logic          w_wpc;
  logic          w_wir;
  logic [1:0]    w_pcsrc;
  logic          w_aluimm;
  logic          w_sext;
  logic          w_shift;
  logic [AW-1:0] w_aluc;
  logic          w_regrt;
  logic          w_jal;
  logic          w_m2reg;
  logic          w_wreg;
  logic          w_wmem;
  logic          w_illegal;
  logic          w_taken;

  multicycle_ctrl_insn_decode u_decode (
    .i_op   (bus.op),
    .i_func (bus.func),
    .o_cls  (w_cls)
  );

  // State register. Reset always returns to fetch; whatever write the
  // interrupted instruction still owed is simply never issued.
  always_ff @(posedge clk) begin
    if (!clrn) r_state <= S_IF;
    else       r_state <= w_next;
  end

  assign w_taken = (w_cls.isBeq & bus.rsrtequ) | (w_cls.isBne & ~bus.rsrtequ);

  // Next-state and output decode. Only one write-type event happens per
  // state, and the ready-gated states issue nothing while waiting. The
  // ALU controls are driven from EX onward so they stay stable for the
  // whole execute/memory/write-back span of the same instruction.
  always_comb begin
    w_next    = r_state;
    w_wpc     = 1'b0;
    w_wir     = 1'b0;
    w_pcsrc   = PC_SEQ;
    w_aluimm  = 1'b0;
    w_sext    = 1'b0;
    w_shift   = 1'b0;
    w_aluc    = ALUC_ADD;
    w_regrt   = 1'b0;
    w_jal     = 1'b0;
    w_m2reg   = 1'b0;
    w_wreg    = 1'b0;
    w_wmem    = 1'b0;
    w_illegal = 1'b0;

    if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
      w_aluimm = w_cls.aluimm;
      w_sext   = w_cls.sext;
      w_shift  = w_cls.shift;
      w_aluc   = w_cls.aluc;
    end

    case (r_state)
      S_IF: begin
        w_wir = bus.imem_rdy;
        w_wpc = bus.imem_rdy;
        if (bus.imem_rdy) w_next = S_ID;
      end
      S_ID: begin
        if (w_cls.isIllegal) begin
          w_illegal = 1'b1;
          w_next    = S_IF;
        end else if (w_cls.isJ) begin
          w_wpc   = 1'b1;
          w_pcsrc = PC_JUMP;
          w_next  = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        if (w_cls.isBeq | w_cls.isBne) begin
          w_wpc   = w_taken;
          w_pcsrc = w_taken ? PC_BRANCH : PC_SEQ;
          w_next  = S_IF;
        end else if (w_cls.isJr) begin
          w_wpc   = 1'b1;
          w_pcsrc = PC_REG;
          w_next  = S_IF;
        end else if (w_cls.isJal) begin
          w_wpc   = 1'b1;
          w_pcsrc = PC_JUMP;
          w_next  = S_WB;
        end else if (w_cls.isLw | w_cls.isSw) begin
          w_next = S_MEM;
        end else if (w_cls.isRtype | w_cls.isIalu) begin
          w_next = S_WB;
        end else begin
          w_next = S_IF;
        end
      end
      S_MEM: begin
        w_wmem = bus.dmem_rdy & w_cls.isSw;
        if (bus.dmem_rdy) w_next = w_cls.isLw ? S_WB : S_IF;
      end
      S_WB: begin
        w_wreg  = 1'b1;
        w_regrt = w_cls.isIalu | w_cls.isLw;
        w_m2reg = w_cls.isLw;
        w_jal   = w_cls.isJal;
        w_next  = S_IF;
      end
      default: w_next = S_IF;
    endcase

    if (!clrn) begin
      w_wpc     = 1'b0;
      w_wir     = 1'b0;
      w_wreg    = 1'b0;
      w_wmem    = 1'b0;
      w_illegal = 1'b0;
    end
  end

  assign bus.wpc     = w_wpc;
  assign bus.wir     = w_wir;
  assign bus.pcsrc   = w_pcsrc;
  assign bus.aluimm  = w_aluimm;
  assign bus.sext    = w_sext;
  assign bus.shift   = w_shift;
  assign bus.aluc    = w_aluc;
  assign bus.regrt   = w_regrt;
  assign bus.jal     = w_jal;
  assign bus.m2reg   = w_m2reg;
  assign bus.wreg    = w_wreg;
  assign bus.wmem    = w_wmem;
  assign bus.illegal = w_illegal;
  assign bus.state   = r_state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the MIPS-subset CPU datapath. Sequences each instruction through IF/ID/EX/MEM/WB. Drives operand-B select (aluimm), ALU opcode, register/memory write enables, PC/IR write enables and PC source. Sits beside the decode stage; consumes op/func from the IR and ready handshakes from instruction and data memory.

Parameters:
- RA_REG, 5'd31, destination register for jal.
- AW, 4, ALU control width.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  synchronous active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- rsrtequ  in  1  qa==qb, from register-file compare.
- imem_rdy  in  1  instruction word valid this cycle.
- dmem_rdy  in  1  data access complete this cycle.
- wpc  out  1  PC write enable.
- wir  out  1  IR write enable.
- pcsrc  out  2  00 pc+4, 01 branch target, 10 register (jr), 11 jump target.
- aluimm  out  1  ALU B = extended immediate (1) / qb (0).
- sext  out  1  sign-extend (1) / zero-extend (0) immediate.
- shift  out  1  ALU A = shamt.
- aluc  out  AW  ALU operation.
- regrt  out  1  destination = rt (1) / rd (0).
- jal  out  1  destination = RA_REG, write data = pc+4.
- m2reg  out  1  write-back data from memory.
- wreg  out  1  register-file write enable.
- wmem  out  1  data-memory write enable.
- illegal  out  1  one-cycle pulse on undecodable instruction.
- state  out  3  current state, for debug.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. State register only; all outputs are combinational decode of state, op, func, rsrtequ and the ready inputs.
- clrn low at posedge: state <= IF. While clrn low, wpc, wir, wreg, wmem, illegal forced 0.
- IF: wir=imem_rdy. Stays in IF while imem_rdy=0, with all enables 0. On imem_rdy=1: wpc=1, pcsrc=00, go to ID.
- ID: decode class. j: wpc=1, pcsrc=11, go to IF. jal and jr go to EX. Illegal op/func: illegal=1, go to IF with no writes.
- EX, ALU classes: aluimm=1 for addi/andi/ori/xori/lui/lw/sw, else 0. sext=1 for addi/lw/sw/beq/bne, 0 for andi/ori/xori. shift=1 for sll/srl/sra.
- EX, next state: R-type and I-ALU go to WB. lw/sw go to MEM.
- EX, beq/bne: if (beq&rsrtequ)|(bne&~rsrtequ), then wpc=1, pcsrc=01. Go to IF in either case.
- EX, jr: wpc=1, pcsrc=10, go to IF.
- EX, jal: wpc=1, pcsrc=11, go to WB.
- aluc encodings: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111. aluc/aluimm/sext/shift are held stable from EX through MEM/WB for the same instruction.
- MEM: wmem=dmem_rdy&sw. Stays in MEM while dmem_rdy=0. On dmem_rdy=1: sw goes to IF, lw goes to WB.
- WB: wreg=1. regrt=1 for I-type, m2reg=1 for lw, jal=1 for jal. Go to IF.
- Cycle counts with zero wait states: j 2; beq/bne/jr 3; R/I-ALU/sw/jal 4; lw 5. Each wait cycle adds 1.
- Exactly one of wpc/wreg/wmem-write events per instruction is permitted in each state. No write enable is ever asserted in a wait cycle.
- Reset mid-instruction: the pending write is dropped and fetch restarts from the datapath's PC.

Decomposition:
- Shared package ctrl_pkg: state encodings; op/func constants (OP_RTYPE 000000, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011; func ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, SRA 000011, JR 001000); aluc constants.
- Sub-module insn_decode (combinational): op/func to class flags and aluc. The FSM in multicycle_ctrl consumes the flags.

Test Plan:
- addi (op 001000), no waits -> states IF,ID,EX,WB. aluimm=1, sext=1, aluc=0000 in EX; regrt=1, wreg=1 only in WB; wpc=1 only in IF.
- lw with imem_rdy low 2 cycles and dmem_rdy low 3 cycles -> 10 cycles total. wreg=1 once with m2reg=1. No enables asserted during waits.
- beq rsrtequ=1 then rsrtequ=0 -> pcsrc=01, wpc=1 in EX for the first; wpc=0 in EX for the second; both return to IF after 3 cycles.
- sll func 000000 -> shift=1, aluimm=0, aluc=0011; then jal -> pcsrc=11 in EX, jal=1 and wreg=1 in WB.
- Illegal op 111111 -> illegal=1 for exactly 1 cycle in ID, next state IF, wreg/wmem never asserted.
- clrn driven low during MEM of sw -> wmem=0, state=IF next edge. After release, the next instruction fetches normally.
